// File: rtl/isa_io_initiator.sv
// ISA I/O cycle generator: turns a single-outstanding command handshake into 8-bit ISA I/O cycles.
// Define ISA_IO16_EN to widen the data path to 16 bits with SBHE#/IOCS16# support.
module isa_io_initiator #(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 6,
   parameter int HOLD_CYCLES   = 2,
   parameter int RDY_TIMEOUT   = 1024,
`ifdef ISA_IO16_EN
   localparam int DW = 16
`else
   localparam int DW = 8
`endif
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [9:0]    cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_timeout,
   output logic [9:0]    isa_addr,
   output logic          isa_aen,
   output logic          isa_ior_n,
   output logic          isa_iow_n,
   output logic [DW-1:0] isa_data_out,
   output logic          isa_data_oe,
   input  logic [DW-1:0] isa_data_in,
   input  logic          isa_iochrdy,
`ifdef ISA_IO16_EN
   input  logic          cmd_wide,
   output logic          isa_sbhe_n,
   input  logic          isa_iocs16_n,
   output logic          rsp_is16,
`endif
   output logic          busy
);

   localparam int SW = $clog2(SETUP_CYCLES + 1);
   localparam int TW = $clog2(STROBE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int WW = $clog2(RDY_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_RDY, HOLD} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] setup_cnt_q, setup_cnt_d;
   logic [TW-1:0] strobe_cnt_q, strobe_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [9:0]    addr_q, addr_d;
   logic          write_q, write_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          timeout_q, timeout_d;
   logic          rdy_meta_q, rdy_s_q;
   logic [DW-1:0] rd_capture;
   logic          strobe_on;
`ifdef ISA_IO16_EN
   logic          wide_q, wide_d;
   logic          is16_q, is16_d;
`endif

   // Read data as seen at strobe release; writes report zero.
   always_comb begin
      rd_capture = write_q ? '0 : isa_data_in;
`ifdef ISA_IO16_EN
      if (!write_q && !(wide_q && is16_q)) rd_capture[15:8] = wide_q ? 8'hFF : 8'h00;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         setup_cnt_q  <= '0;
         strobe_cnt_q <= '0;
         hold_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         timeout_q    <= 1'b0;
         rdy_meta_q   <= 1'b1;
         rdy_s_q      <= 1'b1;
`ifdef ISA_IO16_EN
         wide_q       <= 1'b0;
         is16_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         setup_cnt_q  <= setup_cnt_d;
         strobe_cnt_q <= strobe_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         timeout_q    <= timeout_d;
         rdy_meta_q   <= isa_iochrdy;
         rdy_s_q      <= rdy_meta_q;
`ifdef ISA_IO16_EN
         wide_q       <= wide_d;
         is16_q       <= is16_d;
`endif
      end
   end

   // Handshake: a command is taken on a clock where cmd_valid && cmd_ready (IDLE only);
   // rsp_valid is a one-clock pulse with no back-pressure, rsp_* held until the next accept.
   always_comb begin
      state_d      = state_q;
      setup_cnt_d  = '0;
      strobe_cnt_d = '0;
      hold_cnt_d   = '0;
      wait_cnt_d   = wait_cnt_q;
      addr_d       = addr_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      timeout_d    = timeout_q;
`ifdef ISA_IO16_EN
      wide_d       = wide_q;
      is16_d       = is16_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d    = SETUP;
               addr_d     = cmd_addr;
               write_d    = cmd_write;
               wdata_d    = cmd_wdata;
               wait_cnt_d = '0;
`ifdef ISA_IO16_EN
               wide_d     = cmd_wide;
               is16_d     = 1'b0;
`endif
            end
         end
         SETUP: begin
            if (setup_cnt_q == SW'(SETUP_CYCLES - 1)) begin
               state_d = STROBE;
`ifdef ISA_IO16_EN
               is16_d  = !isa_iocs16_n;
`endif
            end else begin
               setup_cnt_d = setup_cnt_q + SW'(1);
            end
         end
         STROBE: begin
            if (strobe_cnt_q == TW'(STROBE_CYCLES - 1)) begin
               if (rdy_s_q) begin
                  state_d   = HOLD;
                  rdata_d   = rd_capture;
                  timeout_d = 1'b0;
               end else begin
                  state_d = WAIT_RDY;
               end
            end else begin
               strobe_cnt_d = strobe_cnt_q + TW'(1);
            end
         end
         WAIT_RDY: begin
            if (rdy_s_q) begin
               state_d   = HOLD;
               rdata_d   = rd_capture;
               timeout_d = 1'b0;
            end else if (wait_cnt_q == WW'(RDY_TIMEOUT - 1)) begin
               // Counter parks at RDY_TIMEOUT until the next accept clears it.
               state_d    = HOLD;
               wait_cnt_d = WW'(RDY_TIMEOUT);
               rdata_d    = '1;
               timeout_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end
         HOLD: begin
            if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
            else hold_cnt_d = hold_cnt_q + HW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign strobe_on    = (state_q == STROBE) || (state_q == WAIT_RDY);
   assign busy         = (state_q != IDLE);
   assign cmd_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == HOLD) && (hold_cnt_q == '0);
   assign rsp_rdata    = rdata_q;
   assign rsp_timeout  = timeout_q;
   assign isa_addr     = addr_q;
   assign isa_aen      = (state_q == IDLE);
   assign isa_ior_n    = !(strobe_on && !write_q);
   assign isa_iow_n    = !(strobe_on && write_q);
   assign isa_data_out = wdata_q;
   assign isa_data_oe  = write_q && busy;
`ifdef ISA_IO16_EN
   assign isa_sbhe_n   = !(wide_q && busy);
   assign rsp_is16     = is16_q;
`endif

endmodule

// File: tb/tb_isa_io_initiator.sv
// Bench for isa_io_initiator: randomized I/O cycles against a cycle-count reference model and scoreboard.
module tb_isa_io_initiator;

   localparam int SETUP = 2;
   localparam int STRB  = 6;
   localparam int HOLDC = 2;
   localparam int T     = 16;

   typedef struct {
      logic       write;
      logic [9:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       tmo;
      int         l_end;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [9:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_timeout;
   logic [9:0] isa_addr;
   logic       isa_aen;
   logic       isa_ior_n;
   logic       isa_iow_n;
   logic [7:0] isa_data_out;
   logic       isa_data_oe;
   logic [7:0] isa_data_in = '0;
   logic       iochrdy = 1'b1;
   logic       busy;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   ior_cnt = 0;
   int   iow_cnt = 0;
   int   aen_run = 0;

   isa_io_initiator #(
      .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STRB), .HOLD_CYCLES(HOLDC), .RDY_TIMEOUT(T)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .isa_addr(isa_addr), .isa_aen(isa_aen), .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
      .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_data_in(isa_data_in),
      .isa_iochrdy(iochrdy), .busy(busy)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model. Cycle 0 is the accept clock; iochrdy is held low for lo clocks from the
   // first strobe clock and reaches the FSM two clocks later through the synchroniser.
   function automatic void model(input logic wr, input int lo, input logic [7:0] base,
                                 output int l_end, output logic tmo, output logic [7:0] rdata);
      int last_min;
      int seen;
      last_min = SETUP + STRB;
      seen     = (lo == 0) ? 0 : SETUP + 1 + lo + 2;
      l_end    = (seen > last_min) ? seen : last_min;
      tmo      = (l_end > last_min + T);
      if (tmo) l_end = last_min + T;
      rdata    = tmo ? 8'hFF : (wr ? 8'h00 : 8'(int'(base) + l_end));
   endfunction

   // Driver: called on a falling edge while the DUT is idle; returns on the falling edge of the
   // first idle clock after the transaction, so a held cmd_valid gives back-to-back accepts.
   task automatic do_txn(input logic wr, input logic [9:0] addr, input logic [7:0] wd,
                         input int lo, input logic [7:0] base, input bit hold);
      exp_t e;
      int   g;
      bit   ready_ok;
      g = 0;
      while (!cmd_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("ready_before_issue", cmd_ready, 1);
      if (!cmd_ready) return;
      e.write = wr;
      e.addr  = addr;
      e.wdata = wd;
      model(wr, lo, base, e.l_end, e.tmo, e.rdata);
      exp_q.push_back(e);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      @(posedge clk);
      ready_ok = 1'b1;
      for (int n = 1; n <= e.l_end + HOLDC; n++) begin
         @(negedge clk);
         if (n == 1 && !hold) cmd_valid = 1'b0;
         iochrdy     = !(n >= SETUP + 1 && n < SETUP + 1 + lo);
         isa_data_in = 8'(int'(base) + n);
         if (cmd_ready) ready_ok = 1'b0;
         if (n == e.l_end + 1) check("rsp_time", rsp_valid, 1);
      end
      check("ready_low_busy", ready_ok, 1);
      @(negedge clk);
      iochrdy = 1'b1;
      check("idle_ready", cmd_ready, 1);
      check("idle_aen", isa_aen, 1);
      check("idle_oe", isa_data_oe, 0);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      check("strobe_excl", (!isa_ior_n && !isa_iow_n), 0);
      if (isa_aen) begin
         ior_cnt = 0;
         iow_cnt = 0;
         aen_run = 0;
      end else begin
         aen_run++;
         if (!isa_ior_n) ior_cnt++;
         if (!isa_iow_n) iow_cnt++;
      end
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, mon_e.rdata);
            check("rsp_timeout", rsp_timeout, mon_e.tmo);
            check("ior_low_clocks", ior_cnt, mon_e.write ? 0 : mon_e.l_end - SETUP);
            check("iow_low_clocks", iow_cnt, mon_e.write ? mon_e.l_end - SETUP : 0);
            check("aen_low_clocks", aen_run, mon_e.l_end + 1);
            check("hold_addr", isa_addr, mon_e.addr);
            check("hold_oe", isa_data_oe, mon_e.write);
            if (mon_e.write) check("hold_wdata", isa_data_out, mon_e.wdata);
         end
      end
   end

   // Stimulus
   initial begin
      int lo;
      logic wr;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_isa_addr", isa_addr, 0);
      check("rst_aen", isa_aen, 1);
      check("rst_ior_n", isa_ior_n, 1);
      check("rst_iow_n", isa_iow_n, 1);
      check("rst_data_out", isa_data_out, 0);
      check("rst_data_oe", isa_data_oe, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      @(negedge clk);

      do_txn(1'b1, 10'h3F2, 8'hA5, 0, 8'h00, 1'b0);
      do_txn(1'b0, 10'h1F7, 8'h00, 0, 8'h48, 1'b0);
      do_txn(1'b0, 10'h1F7, 8'h00, 20, 8'h30, 1'b0);
      do_txn(1'b0, 10'h2A0, 8'h00, 40, 8'h11, 1'b0);
      for (int k = 0; k < 3; k++)
         do_txn(1'b1, 10'(10'h370 + k), 8'(8'h10 + k), 0, 8'h00, (k < 2));

      // Reset in the middle of a write strobe
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 10'h3F5;
      cmd_wdata = 8'h3C;
      @(posedge clk);
      for (int n = 1; n <= SETUP + 2; n++) begin
         @(negedge clk);
         if (n == 1) cmd_valid = 1'b0;
      end
      check("mid_iow_low", isa_iow_n, 0);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_iow_n", isa_iow_n, 1);
      check("mid_rst_aen", isa_aen, 1);
      check("mid_rst_oe", isa_data_oe, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      reset_n = 1'b1;
      repeat (15) @(negedge clk);
      do_txn(1'b1, 10'h3F4, 8'h5A, 0, 8'h00, 1'b0);

      for (int k = 0; k < 40; k++) begin
         wr = 1'($urandom_range(0, 1));
         lo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
         do_txn(wr, 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)), lo,
                8'($urandom_range(0, 255)), (k < 39) && ($urandom_range(0, 1) == 1));
      end

      repeat (5) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
